coin_pulse_scheduler: RTL

COIN_PULSE_SCHEDULER -- requirements
Module: coin_pulse_scheduler

---
 rtl/coin_pulse_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/coin_pulse_scheduler.sv
// Queues coin requests per source and replays them as fixed-width, gap-separated
// pulses on two coin slots. Sources are served round-robin and one pulse is in flight at a time.
module coin_pulse_scheduler #(
  parameter logic [23:0] PULSE_LEN = 24'd600000,
  parameter logic [23:0] GAP_LEN   = 24'd600000,
  parameter logic [3:0]  SLOT_MAP  = 4'b1100
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce,
  input  logic [3:0] req,
  input  logic       enable,
  input  logic       flush,
  output logic [1:0] coin_out,
  output logic       busy,
  output logic       pend_any,
  output logic [3:0] overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       req_q;
  logic [3:0][3:0]  cnt_q, cnt_d;
  logic [3:0]       ovf_q, ovf_d;
  logic [23:0]      timer_q, timer_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       coin_q, coin_d;

  logic [3:0]       rise;
  logic [3:0]       nonzero;
  logic             gnt_vld;
  logic [1:0]       gnt_idx;
  logic [1:0]       cand;
  logic             grant;

  assign rise = req & ~req_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nonzero[i] = (cnt_q[i] != 4'd0);
    end
  end

  // Walk last+4 down to last+1 so the nearest candidate after 'last' is the one left standing.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last_q;
    cand    = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (nonzero[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign grant = (state_q == S_IDLE) && enable && gnt_vld;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int i = 0; i < 4; i++) begin
      if (rise[i] && (cnt_q[i] == 4'd15) && !(grant && (gnt_idx == 2'(i)))) begin
        ovf_d[i] = 1'b1;
      end
      if (flush) begin
        cnt_d[i] = 4'd0;
      end else if (rise[i] && !(grant && (gnt_idx == 2'(i)))) begin
        cnt_d[i] = (cnt_q[i] == 4'd15) ? 4'd15 : cnt_q[i] + 4'd1;
      end else if (!rise[i] && grant && (gnt_idx == 2'(i))) begin
        cnt_d[i] = cnt_q[i] - 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    coin_d  = coin_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          last_d  = gnt_idx;
          timer_d = PULSE_LEN - 24'd1;
          coin_d  = SLOT_MAP[gnt_idx] ? 2'b10 : 2'b01;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        if (ce) begin
          if (timer_q == 24'd0) begin
            coin_d  = 2'b00;
            timer_d = GAP_LEN - 24'd1;
            state_d = S_GAP;
          end else begin
            timer_d = timer_q - 24'd1;
          end
        end
      end
      S_GAP: begin
        if (ce) begin
          if (timer_q == 24'd0) begin
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q - 24'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        coin_d  = 2'b00;
      end
    endcase
  end

  // last resets to 3 so source 0 is first in line after reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      req_q   <= 4'b0000;
      cnt_q   <= '0;
      ovf_q   <= 4'b0000;
      timer_q <= 24'd0;
      last_q  <= 2'd3;
      coin_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      req_q   <= req;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      timer_q <= timer_d;
      last_q  <= last_d;
      coin_q  <= coin_d;
    end
  end

  assign coin_out = coin_q;
  assign busy     = (state_q != S_IDLE);
  assign pend_any = |nonzero;
  assign overflow = ovf_q;

endmodule
